// File: rtl/rv32m_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on one shared 2*XLEN accumulator, XLEN iterations per op.
module rv32m_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [2:0]          f3_q, f3_d;
  logic [4:0]          rd_q, rd_d, rdo_q, rdo_d;
  logic                neg_q, neg_d;
  logic [XLEN-1:0]     b_q, b_d, res_q, res_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;

  logic                a_s, b_s, a_neg, b_neg, ovf;
  logic [XLEN-1:0]     a_mag, b_mag, neg_min;
  logic [XLEN:0]       msum, tr;
  logic                ge;
  logic [2*XLEN-1:0]   mstep, dstep, step, prod_s;
  logic [XLEN-1:0]     quo, rem, fin;

  // Magnitudes fit in XLEN bits unsigned: |0x80000000| is 2^31.
  always_comb begin
    a_s     = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    b_s     = funct3[2] ? ~funct3[0] : ~funct3[1];
    a_neg   = a_s & op_a[XLEN-1];
    b_neg   = b_s & op_b[XLEN-1];
    a_mag   = a_neg ? -op_a : op_a;
    b_mag   = b_neg ? -op_b : op_b;
    neg_min = {1'b1, {(XLEN-1){1'b0}}};
    ovf     = funct3[2] & ~funct3[0] & (op_a == neg_min) & (op_b == '1);
  end

  // Mul: acc = {hi, multiplier}; Div: acc = {remainder, dividend/quotient}.
  always_comb begin
    msum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mstep = {msum, acc_q[XLEN-1:1]};
    tr    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    ge    = tr >= {1'b0, b_q};
    dstep = {ge ? (tr[XLEN-1:0] - b_q) : tr[XLEN-1:0], acc_q[XLEN-2:0], ge};
    step  = f3_q[2] ? dstep : mstep;
    prod_s = neg_q ? -mstep : mstep;
    quo   = dstep[XLEN-1:0];
    rem   = dstep[2*XLEN-1:XLEN];
    if (f3_q[2]) begin
      if (f3_q[1]) fin = neg_q ? -rem : rem;
      else         fin = neg_q ? -quo : quo;
    end else begin
      fin = (f3_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    rdo_d   = rdo_q;
    neg_d   = neg_q;
    b_d     = b_q;
    acc_d   = acc_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: if (start && !kill) begin
        f3_d    = funct3;
        rd_d    = rd_in;
        count_d = '0;
        neg_d   = (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);
        b_d     = funct3[2] ? b_mag : a_mag;
        acc_d   = {{XLEN{1'b0}}, funct3[2] ? a_mag : b_mag};
        state_d = CALC;
        if (funct3[2] && (op_b == '0 || ovf)) begin
          if (op_b == '0) res_d = funct3[1] ? op_a : '1;
          else            res_d = funct3[1] ? '0 : neg_min;
          rdo_d   = rd_in;
          state_d = DONE;
        end
      end
      CALC: begin
        if (kill) state_d = IDLE;
        else begin
          acc_d   = step;
          count_d = count_q + 1'b1;
          if (count_q == CW'(XLEN-1)) begin
            res_d   = fin;
            rdo_d   = rd_q;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      rdo_q   <= '0;
      neg_q   <= 1'b0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      rdo_q   <= rdo_d;
      neg_q   <= neg_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = res_q;
  assign rd_out = rdo_q;
endmodule

// File: tb/tb_rv32m_muldiv.sv
// Directed-vector bench for rv32m_muldiv: arithmetic results, latency, kill, reset, start-hold.
module tb_rv32m_muldiv;
  logic        clk = 1'b0;
  logic        rst_n, start, kill;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b, result;
  logic [4:0]  rd_in, rd_out;
  logic        busy, done;
  int          errs = 0, checks = 0;

  rv32m_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3), .op_a(op_a),
    .op_b(op_b), .rd_in(rd_in), .kill(kill), .busy(busy), .done(done),
    .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Launch one op at edge E0, scramble operands after capture, wait for done.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int exp_lat);
    int n = 0;
    start = 1'b1; funct3 = f; op_a = a; op_b = b; rd_in = rd;
    tick();
    start = 1'b0; op_a = 32'h5A5A_1234; op_b = 32'h0000_0003; rd_in = 5'd0;
    while (!done && n < 100) begin tick(); n++; end
    chk({tag, " lat"}, n, exp_lat);
    chk({tag, " res"}, result, exp);
    chk({tag, " rd"}, {27'd0, rd_out}, {27'd0, rd});
    tick();
    chk({tag, " pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int n, ndone;
    logic [31:0] held;
    rst_n = 1'b0; start = 1'b0; kill = 1'b0; funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
    tick(); tick();
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst result", result, 32'd0);
    chk("rst rd", {27'd0, rd_out}, 32'd0);
    rst_n = 1'b1;
    tick();

    run_op("MUL",    3'b000, 32'd7,          32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 32);
    run_op("MULH",   3'b001, 32'h8000_0000,  32'h8000_0000, 5'd4,  32'h4000_0000, 32);
    run_op("MULHU",  3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFE, 32);
    run_op("MULHSU", 3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFF, 32);
    run_op("DIV",    3'b100, 32'hFFFF_FFF9,  32'd2,         5'd7,  32'hFFFF_FFFD, 32);
    run_op("REM",    3'b110, 32'hFFFF_FFF9,  32'd2,         5'd8,  32'hFFFF_FFFF, 32);
    run_op("DIVU",   3'b101, 32'd100,        32'd7,         5'd9,  32'd14,        32);
    run_op("REMU",   3'b111, 32'd100,        32'd7,         5'd10, 32'd2,         32);
    run_op("DIVnb",  3'b100, 32'd7,          32'hFFFF_FFFE, 5'd11, 32'hFFFF_FFFD, 32);
    run_op("REMnb",  3'b110, 32'd7,          32'hFFFF_FFFE, 5'd12, 32'd1,         32);
    run_op("DIVmin", 3'b100, 32'h8000_0000,  32'd2,         5'd13, 32'hC000_0000, 32);
    run_op("DIVU0",  3'b101, 32'd5,          32'd0,         5'd14, 32'hFFFF_FFFF, 0);
    run_op("REM0",   3'b110, 32'd5,          32'd0,         5'd15, 32'd5,         0);
    run_op("DIVovf", 3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 0);
    run_op("REMovf", 3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd17, 32'd0,         0);

    // kill at E0+10: back to IDLE, no done, result/rd_out untouched
    held = result;
    start = 1'b1; funct3 = 3'b000; op_a = 32'd9; op_b = 32'd9; rd_in = 5'd20;
    tick(); start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    kill = 1'b1; tick(); kill = 1'b0;
    chk("kill busy", {31'd0, busy}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin if (done) ndone++; tick(); end
    chk("kill nodone", ndone, 0);
    chk("kill result", result, held);
    chk("kill rd", {27'd0, rd_out}, 32'd17);

    // kill together with start in IDLE: nothing accepted
    start = 1'b1; kill = 1'b1; tick(); start = 1'b0; kill = 1'b0;
    chk("killstart busy", {31'd0, busy}, 32'd0);

    // reset mid-CALC
    start = 1'b1; funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd21;
    tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("midrst result", result, 32'd0);
    chk("midrst rd", {27'd0, rd_out}, 32'd0);
    chk("midrst busy", {31'd0, busy}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin if (done) ndone++; tick(); end
    chk("midrst nodone", ndone, 0);

    // start held high: re-accepted only from IDLE, one done per op
    start = 1'b1; funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd22;
    tick();
    n = 0; ndone = 0;
    for (int i = 1; i <= 70; i++) begin
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          n = i;
          chk("hold res", result, 32'd14);
        end
      end
      tick();
    end
    start = 1'b0;
    chk("hold first", n, 33);
    chk("hold count", ndone, 2);
    for (int i = 0; i < 40; i++) tick();
    chk("hold idle", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
